// File: rtl/vga_sync.sv
// 640x480@60 Hz VGA timing generator running on the 25 MHz pixel clock.
// All outputs are registered decodes of the h/v counters, so they stay mutually aligned.
module vga_sync #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CNT_W     = 10
) (
    input  logic             clk_25,
    input  logic             rst_n,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    function automatic logic in_hsync(input logic [CNT_W-1:0] h);
        return (h >= HS_START) && (h < HS_END);
    endfunction

    function automatic logic in_vsync(input logic [CNT_W-1:0] v);
        return (v >= VS_START) && (v < VS_END);
    endfunction

    function automatic logic visible(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
        return (h < H_ACT) && (v < V_ACT);
    endfunction

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Counters advance and the current (h_cnt, v_cnt) point is decoded into the output registers.
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + CNT_W'(1);
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
            end
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
            de          <= visible(h_cnt, v_cnt);
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            vblank      <= (v_cnt >= V_ACT);
            hsync       <= in_hsync(h_cnt) ? HS_ON : ~HS_ON;
            // vsync depends only on the line number, so it flips together with pix_x returning to 0
            vsync       <= in_vsync(v_cnt) ? VS_ON : ~VS_ON;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync: a full-size 640x480 instance over several lines and a
// reduced-geometry instance (15x11 points) over whole frames, wraps and a mid-frame reset.
module tb_vga_sync;

    typedef struct packed {
        logic       rst;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic       vb;
        logic [9:0] x;
        logic [9:0] y;
    } pt_t;

    logic clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    logic       rst_full_n  = 1'b0;
    logic       rst_small_n = 1'b0;

    logic       hs_f, vs_f, de_f, ls_f, fs_f, vb_f;
    logic [9:0] x_f, y_f;
    logic       hs_s, vs_s, de_s, ls_s, fs_s, vb_s;
    logic [9:0] x_s, y_s;

    vga_sync dut_full (
        .clk_25(clk_25), .rst_n(rst_full_n), .hsync(hs_f), .vsync(vs_f), .de(de_f),
        .pix_x(x_f), .pix_y(y_f), .line_start(ls_f), .frame_start(fs_f), .vblank(vb_f)
    );

    // Small geometry: H 8+2+3+2 = 15, V 6+2+2+1 = 11, frame = 165 cycles, hsync active-high.
    vga_sync #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(0), .CNT_W(10)
    ) dut_small (
        .clk_25(clk_25), .rst_n(rst_small_n), .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .pix_x(x_s), .pix_y(y_s), .line_start(ls_s), .frame_start(fs_s), .vblank(vb_s)
    );

    pt_t q_full[$];
    pt_t q_small[$];
    int  passed = 0;
    int  total  = 0;
    bit  done_full  = 0;
    bit  done_small = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic pt_t model(input int x, input int y, input int ha, input int hf,
                                  input int hsw, input int va, input int vf, input int vsw,
                                  input logic hpol, input logic vpol);
        pt_t m;
        m.rst = 1'b0;
        m.hs  = (x >= ha + hf && x < ha + hf + hsw) ? hpol : ~hpol;
        m.vs  = (y >= va + vf && y < va + vf + vsw) ? vpol : ~vpol;
        m.de  = (x < ha) && (y < va);
        m.ls  = (x == 0);
        m.fs  = (x == 0) && (y == 0);
        m.vb  = (y >= va);
        m.x   = 10'(x);
        m.y   = 10'(y);
        return m;
    endfunction

    function automatic pt_t reset_pt(input logic hpol, input logic vpol);
        pt_t m;
        m     = '0;
        m.rst = 1'b1;
        m.hs  = ~hpol;
        m.vs  = ~vpol;
        return m;
    endfunction

    // Full-size driver: 5 reset cycles then three lines and a bit.
    initial begin
        int x = 0;
        int y = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_25);
            rst_full_n = 1'b0;
            q_full.push_back(reset_pt(1'b0, 1'b0));
        end
        for (int i = 0; i < 3 * 800 + 10; i++) begin
            @(negedge clk_25);
            rst_full_n = 1'b1;
            q_full.push_back(model(x, y, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
            x++;
            if (x == 800) begin x = 0; y++; if (y == 525) y = 0; end
        end
        done_full = 1;
    end

    // Small driver: reset, two full frames, run to (5,4), one reset cycle, then restart.
    initial begin
        int x = 0;
        int y = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_25);
            rst_small_n = 1'b0;
            q_small.push_back(reset_pt(1'b1, 1'b0));
        end
        for (int i = 0; i < 2 * 165 + 4 * 15 + 5; i++) begin
            @(negedge clk_25);
            rst_small_n = 1'b1;
            q_small.push_back(model(x, y, 8, 2, 3, 6, 2, 2, 1'b1, 1'b0));
            x++;
            if (x == 15) begin x = 0; y++; if (y == 11) y = 0; end
        end
        @(negedge clk_25);
        rst_small_n = 1'b0;
        q_small.push_back(reset_pt(1'b1, 1'b0));
        x = 0;
        y = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_25);
            rst_small_n = 1'b1;
            q_small.push_back(model(x, y, 8, 2, 3, 6, 2, 2, 1'b1, 1'b0));
            x++;
            if (x == 15) begin x = 0; y++; if (y == 11) y = 0; end
        end
        done_small = 1;
    end

    // Full-size monitor: per-cycle scoreboard plus line, hsync and de run-length checks.
    initial begin
        pt_t e, a;
        int  cyc = 0, last_ls = -1, hs_run = 0, de_run = 0;
        logic [9:0] de_last_x = '0;
        forever begin
            @(posedge clk_25);
            #1;
            if (q_full.size() > 0) begin
                e = q_full.pop_front();
                a = {1'b0, hs_f, vs_f, de_f, ls_f, fs_f, vb_f, x_f, y_f};
                check("full_point", 32'(a), 32'({1'b0, e[25:0]}));
                if (e.rst) begin
                    cyc = 0; last_ls = -1; hs_run = 0; de_run = 0;
                end else begin
                    if (ls_f) begin
                        if (last_ls >= 0) check("line_period", 32'(cyc - last_ls), 32'd800);
                        last_ls = cyc;
                    end
                    if (!hs_f) begin
                        if (hs_run == 0) check("hsync_start_x", 32'(x_f), 32'd656);
                        hs_run++;
                    end else if (hs_run > 0) begin
                        check("hsync_width", 32'(hs_run), 32'd96);
                        hs_run = 0;
                    end
                    if (de_f) begin
                        de_run++;
                        de_last_x = x_f;
                    end else if (de_run > 0) begin
                        check("de_width", 32'(de_run), 32'd640);
                        check("de_last_x", 32'(de_last_x), 32'd639);
                        de_run = 0;
                    end
                    cyc++;
                end
            end
        end
    end

    // Small monitor: per-cycle scoreboard plus frame period and vsync run checks.
    initial begin
        pt_t e, a;
        int  cyc = 0, last_fs = -1, vs_run = 0;
        forever begin
            @(posedge clk_25);
            #1;
            if (q_small.size() > 0) begin
                e = q_small.pop_front();
                a = {1'b0, hs_s, vs_s, de_s, ls_s, fs_s, vb_s, x_s, y_s};
                check("small_point", 32'(a), 32'({1'b0, e[25:0]}));
                if (e.rst) begin
                    cyc = 0; last_fs = -1; vs_run = 0;
                end else begin
                    if (fs_s) begin
                        if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'd165);
                        last_fs = cyc;
                    end
                    if (!vs_s) begin
                        if (vs_run == 0) check("vsync_start_xy", 32'({x_s, y_s}), 32'({10'd0, 10'd8}));
                        vs_run++;
                    end else if (vs_run > 0) begin
                        check("vsync_width", 32'(vs_run), 32'd30);
                        vs_run = 0;
                    end
                    cyc++;
                end
            end
        end
    end

    initial begin
        #(40 * 50000);
        $display("FAIL watchdog: got timeout expected drivers done");
        $fatal(1, "bench timed out");
    end

    initial begin
        wait (done_full && done_small);
        repeat (3) @(posedge clk_25);
        #2;
        check("queues_drained", 32'(q_full.size() + q_small.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
